// File: rtl/sd_cmd_sched_if.sv
// Bus bundle for sd_cmd_sched: per-source request slots, the issue/result
// channel to cmd_logic, and the per-source status pulses.
// Handshake: cmd_valid_o rises in ISSUE and holds with stable cmd/arg/rsp_type
// until sampled together with cmd_ready_i on a rising edge; it is never
// withdrawn. result_valid_i and timeout_error_i are unhandshaked one-cycle
// strobes that only count while the scheduler waits for a result.
interface sd_cmd_sched_if #(
  parameter int NumSrc = 2
);
  localparam int SrcW = (NumSrc > 1) ? $clog2(NumSrc) : 1;

  logic [NumSrc-1:0]         req_valid_i;
  logic [NumSrc-1:0][5:0]    req_cmd_i;
  logic [NumSrc-1:0][31:0]   req_arg_i;
  logic [NumSrc-1:0][1:0]    req_rsp_type_i;
  logic [NumSrc-1:0]         req_drop_o;
  logic [NumSrc-1:0]         inhibit_o;
  logic [NumSrc-1:0]         done_o;
  logic [NumSrc-1:0]         aborted_o;
  logic [3:0]                err_o;
  logic [119:0]              rsp_o;
  logic [SrcW-1:0]           rsp_src_o;
  logic [5:0]                cmd_o;
  logic [31:0]               arg_o;
  logic [1:0]                rsp_type_o;
  logic                      cmd_valid_o;
  logic                      cmd_ready_i;
  logic                      result_valid_i;
  logic [119:0]              rsp_i;
  logic                      end_bit_error_i;
  logic                      crc_error_i;
  logic                      index_error_i;
  logic                      timeout_error_i;
  logic [1:0]                state_dbg;

  modport slave (
    input  req_valid_i, req_cmd_i, req_arg_i, req_rsp_type_i,
    input  cmd_ready_i, result_valid_i, rsp_i,
    input  end_bit_error_i, crc_error_i, index_error_i, timeout_error_i,
    output req_drop_o, inhibit_o, done_o, aborted_o, err_o, rsp_o, rsp_src_o,
    output cmd_o, arg_o, rsp_type_o, cmd_valid_o, state_dbg
  );

  modport master (
    output req_valid_i, req_cmd_i, req_arg_i, req_rsp_type_i,
    output cmd_ready_i, result_valid_i, rsp_i,
    output end_bit_error_i, crc_error_i, index_error_i, timeout_error_i,
    input  req_drop_o, inhibit_o, done_o, aborted_o, err_o, rsp_o, rsp_src_o,
    input  cmd_o, arg_o, rsp_type_o, cmd_valid_o, state_dbg
  );
endinterface

// File: rtl/sd_cmd_sched.sv
// Multi-source SD command scheduler: per-source request slots, fixed
// priority issue (index 0 first), result routing and abort-on-failure.
// Optional macro SDHCI_CMD_RETRY_EN: a lone CRC error re-issues the same
// command up to MaxRetries times before it is reported as a failure.
module sd_cmd_sched #(
  parameter int NumSrc     = 2,
  parameter int MaxRetries = 2
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  sd_cmd_sched_if.slave  bus
);
  localparam int SrcW = (NumSrc > 1) ? $clog2(NumSrc) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2} state_e;

  if (NumSrc < 1 || NumSrc > 8 || MaxRetries < 0) begin : g_bad_param
    $error("sd_cmd_sched: NumSrc must be 1..8 and MaxRetries >= 0");
  end

  state_e                  state_q, state_d;
  logic [NumSrc-1:0]       pend_q;
  logic [NumSrc-1:0][5:0]  slot_cmd_q;
  logic [NumSrc-1:0][31:0] slot_arg_q;
  logic [NumSrc-1:0][1:0]  slot_typ_q;
  logic [SrcW-1:0]         cur_q;
  logic [5:0]              cmd_q;
  logic [31:0]             arg_q;
  logic [1:0]              typ_q;
  logic [NumSrc-1:0]       done_q, aborted_q, drop_q;
  logic [NumSrc-1:0]       done_d, inhibit;
  logic [3:0]              err_q, errs;
  logic [119:0]            rsp_q;
  logic [SrcW-1:0]         rsp_src_q;
  logic [SrcW-1:0]         pick_idx;
  logic                    any_pend, cpl_q, res, take, finish, fail, retry;

  // Error vector in err_o bit order; a result is any strobe while waiting.
  assign errs     = {bus.end_bit_error_i, bus.crc_error_i, bus.index_error_i, bus.timeout_error_i};
  assign res      = (state_q == S_WAIT) && (bus.result_valid_i || bus.timeout_error_i);
  assign any_pend = |pend_q;
  // A completion pulse is in flight; holding IDLE one extra cycle keeps the
  // status pulse and the next issue apart.
  assign cpl_q    = |done_q;
  assign take     = (state_q == S_IDLE) && any_pend && !cpl_q;
  assign finish   = res && !retry;
  assign fail     = finish && (|errs);

`ifdef SDHCI_CMD_RETRY_EN
  localparam int RetryW = (MaxRetries < 1) ? 1 : $clog2(MaxRetries + 1);
  logic [RetryW-1:0] retry_q;

  assign retry = res && (errs == 4'b0100) && (retry_q < RetryW'(MaxRetries));

  // Attempt counter: cleared when a command is taken, bumped per retry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    retry_q <= '0;
    else if (take)  retry_q <= '0;
    else if (retry) retry_q <= retry_q + 1'b1;
  end
`else
  assign retry = 1'b0;
`endif

  // Lowest pending index wins.
  always_comb begin
    pick_idx = '0;
    for (int i = NumSrc - 1; i >= 0; i--) begin
      if (pend_q[i]) pick_idx = SrcW'(i);
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (take) state_d = S_ISSUE;
      S_ISSUE: if (bus.cmd_ready_i) state_d = S_WAIT;
      S_WAIT:  if (res) state_d = retry ? S_ISSUE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Combinational outputs: per-source inhibit and completion one-hot.
  always_comb begin
    inhibit = '0;
    done_d  = '0;
    for (int i = 0; i < NumSrc; i++) begin
      inhibit[i] = pend_q[i] || ((state_q != S_IDLE) && (cur_q == SrcW'(i)));
      done_d[i]  = finish && (cur_q == SrcW'(i));
    end
  end

  // Request slots: load when clear, release on take or on a failure abort.
  // A strobe in the failure cycle lands in a clear slot and survives.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q     <= '0;
      slot_cmd_q <= '0;
      slot_arg_q <= '0;
      slot_typ_q <= '0;
    end else begin
      for (int i = 0; i < NumSrc; i++) begin
        if (bus.req_valid_i[i] && !pend_q[i]) begin
          pend_q[i]     <= 1'b1;
          slot_cmd_q[i] <= bus.req_cmd_i[i];
          slot_arg_q[i] <= bus.req_arg_i[i];
          slot_typ_q[i] <= bus.req_rsp_type_i[i];
        end else if ((take && (pick_idx == SrcW'(i))) || fail) begin
          pend_q[i] <= 1'b0;
        end
      end
    end
  end

  // Issue register: the taken slot is copied so the slot can refill while
  // its command is in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cur_q <= '0;
      cmd_q <= '0;
      arg_q <= '0;
      typ_q <= '0;
    end else if (take) begin
      cur_q <= pick_idx;
      cmd_q <= slot_cmd_q[pick_idx];
      arg_q <= slot_arg_q[pick_idx];
      typ_q <= slot_typ_q[pick_idx];
    end
  end

  // Status pulses and completion record (response held until the next one).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_q    <= '0;
      aborted_q <= '0;
      drop_q    <= '0;
      err_q     <= '0;
      rsp_q     <= '0;
      rsp_src_q <= '0;
    end else begin
      done_q    <= done_d;
      aborted_q <= fail ? pend_q : '0;
      drop_q    <= bus.req_valid_i & pend_q;
      if (finish) begin
        err_q     <= errs;
        rsp_q     <= bus.rsp_i;
        rsp_src_q <= cur_q;
      end
    end
  end

  assign bus.cmd_valid_o = (state_q == S_ISSUE);
  assign bus.cmd_o       = cmd_q;
  assign bus.arg_o       = arg_q;
  assign bus.rsp_type_o  = typ_q;
  assign bus.inhibit_o   = inhibit;
  assign bus.done_o      = done_q;
  assign bus.aborted_o   = aborted_q;
  assign bus.req_drop_o  = drop_q;
  assign bus.err_o       = err_q;
  assign bus.rsp_o       = rsp_q;
  assign bus.rsp_src_o   = rsp_src_q;
  assign bus.state_dbg   = state_q;
endmodule

// File: doc/sd_cmd_sched.md
# sd_cmd_sched

Parametrised multi-source SD command scheduler sitting between the SDHCI register/data front-end and `cmd_logic`. It captures command requests from `NumSrc` independent sources into per-source slots and issues them one at a time with fixed priority. It routes each response and error set back to the originating source, and aborts outstanding requests on a failed command. An optional automatic retry on CRC error is compiled in by macro. It generalises the driver-command/Auto-CMD12 pairing to N sources.

## Interface
- `NumSrc`, 2: number of request sources; index 0 has the highest priority. Range 1..8.
- `MaxRetries`, 2: retry attempts per command after a CRC error. Used only with the retry feature.
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `req_valid_i` in NumSrc: single-cycle request strobe per source.
- `req_cmd_i` in NumSrc×6: command index per source.
- `req_arg_i` in NumSrc×32: argument per source.
- `req_rsp_type_i` in NumSrc×2: `sdhci_pkg::response_type_e` per source.
- `req_drop_o` out NumSrc: pulse, request ignored because the slot was already pending.
- `inhibit_o` out NumSrc: source slot pending, or source in flight.
- `done_o` out NumSrc: pulse, command of source i completed (with or without error).
- `aborted_o` out NumSrc: pulse, pending request of source i discarded.
- `err_o` out 4: {end_bit, crc, index, timeout}, valid with `done_o`.
- `rsp_o` out 120: last response, held until the next completion.
- `rsp_src_o` out $clog2(NumSrc) (min 1): source index of `rsp_o`.
- `cmd_o` out 6, `arg_o` out 32, `rsp_type_o` out 2: command to `cmd_logic`.
- `cmd_valid_o` out 1 / `cmd_ready_i` in 1: issue handshake.
- `result_valid_i` in 1, `rsp_i` in 120, `end_bit_error_i`, `crc_error_i`, `index_error_i`, `timeout_error_i` in 1 each: results from `cmd_logic`.

## Operation
- Slots: each source has a pending flag and {cmd, arg, rsp_type} registers.
  - `req_valid_i[i]` with the slot clear: the slot is loaded and pending is set.
  - `req_valid_i[i]` with the slot pending: the request is ignored and `req_drop_o[i]` pulses.
  - A source in flight with its slot clear may queue its next request.
- FSM with three states:
  - IDLE: if any slot is pending, latch the lowest pending index into `cur_q`, clear that slot's pending flag, load the retry count with 0, and go to ISSUE.
  - ISSUE: `cmd_valid_o`=1 with the latched fields. On `cmd_valid_o & cmd_ready_i`, go to WAIT.
  - WAIT: on `result_valid_i` or `timeout_error_i`, register `rsp_i` and the errors and resolve as follows.
    - Success: pulse `done_o[cur_q]`, then IDLE.
    - Failure (any error, retry not taken): pulse `done_o[cur_q]` with `err_o`. Clear every pending slot and pulse `aborted_o` for each one cleared. Then IDLE.
- `rsp_o`/`rsp_src_o` update only on completion. They do not update on a retried attempt.
- `inhibit_o[i]` = pending[i] | (state≠IDLE & `cur_q`==i).
- Abort applies only to slots pending before the failure cycle. A request strobed in the failure cycle is captured and survives.
- A completion and a new request in the same cycle are both handled. The new request is considered in the next IDLE.

## Timing
- Reset values: state IDLE, all slots clear. `cmd_valid_o`, `done_o`, `aborted_o`, `req_drop_o` and `inhibit_o` are 0. `err_o`, `rsp_o`, `rsp_src_o`, `cmd_o`, `arg_o` and `rsp_type_o` are 0.
- Reset mid-command drops everything with no `done_o` or `aborted_o` pulse.
- Issue latency:
  - Strobe at cycle 0: pending and `inhibit_o` at cycle 1, `cmd_valid_o` at cycle 2.
- Completion latency:
  - `result_valid_i` at cycle n: `done_o`, `err_o` and `rsp_o` at n+1. IDLE at n+1.
  - Next `cmd_valid_o` at n+3 at the earliest.
- `cmd_valid_o` holds, with stable fields, until `cmd_ready_i`. It is never withdrawn.
- `timeout_error_i` is unhandshaked and is treated as a result in WAIT only. Outside WAIT it is ignored.

## Configuration
- `SDHCI_CMD_RETRY_EN` defined:
  - In WAIT, `crc_error_i` alone with retry count < `MaxRetries`: increment the count and return to ISSUE with the same fields.
  - No `done_o` pulse and no abort on that attempt.
  - Any other error, or an exhausted count, resolves as a failure.
- Undefined: there is no retry counter, `MaxRetries` is unused, and every error is a failure.

## Test plan
- Single request: source 1 strobes CMD17 with arg 0x1000 and R1. Expect `cmd_valid_o` at +2. Then `result_valid_i` with `rsp_i`=0x900 → `done_o`=2'b10, `rsp_o`=0x900, `rsp_src_o`=1, `err_o`=0.
- Priority: sources 0 and 1 strobe in the same cycle → source 0 is issued first, then source 1. Expect two `done_o` pulses in index order.
- Abort: source 1 in flight, source 0 pending, `index_error_i` on the result → `done_o[1]` with `err_o`=4'b0010, `aborted_o`=2'b01, source 0 never issued.
- Drop: source 0 pending, second strobe on source 0 → `req_drop_o[0]` pulses and the original arg is issued.
- Timeout: `timeout_error_i` in WAIT → `done_o` with `err_o`=4'b0001. `timeout_error_i` in IDLE → no effect.
- Retry (macro defined, `MaxRetries`=2): three consecutive CRC errors → 3 handshakes, then a single `done_o` with `err_o`=4'b0100. CRC error then success → 2 handshakes and `err_o`=0.
